avalon_reg_bridge: RTL and testbench

AVALON_REG_BRIDGE -- requirements
Module: avalon_reg_bridge

---
 rtl/avalon_reg_bridge_pkg.sv | 24 ++
 rtl/avalon_reg_bridge_if.sv | 29 ++
 rtl/avalon_reg_bridge_stage.sv | 27 ++
 rtl/avalon_reg_bridge.sv | 137 +++++++++++++
 tb/tb_avalon_reg_bridge.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_reg_bridge_pkg.sv
// Shared definitions for the Avalon-MM register bridge.
//   RSP_OKAY / RSP_SLVERR : avs_response encodings.
//   stage_t               : one command-pipeline stage. Fields are sized to
//                           package maxima so the type is parameter-free; the
//                           bridge zero-extends into them and uses the low bits.
package avalon_reg_bridge_pkg;

  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;

  localparam int unsigned MAX_ADDR_WIDTH = 16;
  localparam int unsigned MAX_DATA_WIDTH = 256;

  typedef struct packed {
    logic                          valid;
    logic                          read;
    logic                          write;
    logic                          addr_ok;
    logic [MAX_ADDR_WIDTH-1:0]     addr;
    logic [MAX_DATA_WIDTH-1:0]     data;
    logic [MAX_DATA_WIDTH/8-1:0]   byteen;
  } stage_t;

endpackage

// File: rtl/avalon_reg_bridge_if.sv
// Avalon-MM slave bus bundle for avalon_reg_bridge.
//   master : drives read/write/address/writedata/byteenable, sees the response.
//   slave  : the bridge side (waitrequest, readdatavalid, readdata, response).
interface avalon_reg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    avs_read;
  logic                    avs_write;
  logic [ADDR_WIDTH-1:0]   avs_address;
  logic [DATA_WIDTH-1:0]   avs_writedata;
  logic [DATA_WIDTH/8-1:0] avs_byteenable;
  logic                    avs_waitrequest;
  logic                    avs_readdatavalid;
  logic [DATA_WIDTH-1:0]   avs_readdata;
  logic [1:0]              avs_response;

  modport master (
    output avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    input  avs_waitrequest, avs_readdatavalid, avs_readdata, avs_response
  );

  modport slave (
    input  avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    output avs_waitrequest, avs_readdatavalid, avs_readdata, avs_response
  );

endinterface

// File: rtl/avalon_reg_bridge_stage.sv
// reg_bridge_stage: one stallable stage of the bridge command pipeline.
//   clk, reset : clock, asynchronous active-high reset (clears the stage)
//   adv_i      : load d_i this cycle; otherwise hold
//   d_i / q_o  : stage input / registered stage contents
module reg_bridge_stage
  import avalon_reg_bridge_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   adv_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (adv_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/avalon_reg_bridge.sv
// avalon_reg_bridge: Avalon-MM slave to a bank of REGS simple registers.
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : Avalon-MM command/response; waitrequest mirrors reg_busy
//   reg_write_en   : one-hot write strobe, with reg_wdata / reg_byteen
//   reg_read_en    : one-hot read strobe; reg_rdata sampled in the same cycle
//   reg_rdata      : register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_busy       : register-side stall, freezes the command pipeline
//   err_sticky     : set by any out-of-range or read+write command
// A command accepted in cycle N strobes in N+LATENCY-1 and a read returns
// its data in N+LATENCY, each delayed by one cycle per stalled cycle.
module avalon_reg_bridge
  import avalon_reg_bridge_pkg::*;
#(
  parameter int unsigned REGS       = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned ADDR_WIDTH = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  avalon_reg_bridge_if.slave           bus,
  output logic [REGS-1:0]              reg_write_en,
  output logic [REGS-1:0]              reg_read_en,
  output logic [DATA_WIDTH-1:0]        reg_wdata,
  output logic [DATA_WIDTH/8-1:0]      reg_byteen,
  input  logic [REGS*DATA_WIDTH-1:0]   reg_rdata,
  input  logic                         reg_busy,
  output logic                         err_sticky
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                  accept;
  logic                  fire;
  logic [ADDR_WIDTH-1:0] saddr;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  err_q;
  stage_t                cmd;
  stage_t                strb;
  stage_t                resp_d;
  stage_t                resp_q;
  stage_t                stg_q [LATENCY];

  assign bus.avs_waitrequest = reg_busy;
  assign accept = (bus.avs_read | bus.avs_write) & ~reg_busy;

  // Read+write together is executed as a write only.
  always_comb begin
    cmd         = '0;
    cmd.valid   = accept;
    cmd.write   = bus.avs_write;
    cmd.read    = bus.avs_read & ~bus.avs_write;
    cmd.addr_ok = ({1'b0, bus.avs_address} < (ADDR_WIDTH+1)'(REGS));
    cmd.addr    = MAX_ADDR_WIDTH'(bus.avs_address);
    cmd.data    = MAX_DATA_WIDTH'(bus.avs_writedata);
    cmd.byteen  = (MAX_DATA_WIDTH/8)'(bus.avs_byteenable);
  end

  // Strobes come from the input of the last stage: the raw command when
  // LATENCY is 1, otherwise the output of the second-to-last stage.
  if (LATENCY == 1) begin : g_direct
    assign strb = cmd;
  end else begin : g_piped
    assign strb = stg_q[LATENCY-2];
  end

  // The last stage is the response register. It reloads every cycle and
  // takes a bubble while stalled, so a read beat is presented for exactly
  // one cycle even if reg_busy rises while it is on the bus.
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    stage_t d;
    logic   adv;
    if (k == LATENCY - 1) begin : g_last
      assign d   = resp_d;
      assign adv = 1'b1;
    end else if (k == 0) begin : g_first
      assign d   = cmd;
      assign adv = ~reg_busy;
    end else begin : g_mid
      assign d   = stg_q[k-1];
      assign adv = ~reg_busy;
    end
    reg_bridge_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .adv_i (adv),
      .d_i   (d),
      .q_o   (stg_q[k])
    );
  end

  assign fire  = strb.valid & ~reg_busy;
  assign saddr = strb.addr[ADDR_WIDTH-1:0];

  always_comb begin
    reg_write_en = '0;
    reg_read_en  = '0;
    reg_wdata    = '0;
    reg_byteen   = '0;
    rdata_sel    = '0;
    if (fire && strb.addr_ok) begin
      if (strb.write) begin
        reg_write_en[saddr] = 1'b1;
        reg_wdata           = strb.data[DATA_WIDTH-1:0];
        reg_byteen          = strb.byteen[BE_W-1:0];
      end else if (strb.read) begin
        reg_read_en[saddr] = 1'b1;
        rdata_sel          = reg_rdata[saddr*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only reads produce a response beat; out-of-range reads carry zero data.
  always_comb begin
    resp_d         = '0;
    resp_d.valid   = fire & strb.read;
    resp_d.read    = fire & strb.read;
    resp_d.addr_ok = strb.addr_ok;
    resp_d.data    = MAX_DATA_WIDTH'(rdata_sel);
  end

  assign resp_q                = stg_q[LATENCY-1];
  assign bus.avs_readdatavalid = resp_q.valid;
  assign bus.avs_readdata      = resp_q.valid ? resp_q.data[DATA_WIDTH-1:0] : '0;
  assign bus.avs_response      = (resp_q.valid & ~resp_q.addr_ok) ? RSP_SLVERR : RSP_OKAY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && ((bus.avs_read && bus.avs_write) || !cmd.addr_ok)) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky = err_q;

endmodule

// File: tb/tb_avalon_reg_bridge.sv
module tb_avalon_reg_bridge;

  localparam int unsigned REGS = 9;
  localparam int unsigned DW   = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [REGS*DW-1:0] rdata;
  logic b1, b2, b3;
  logic [REGS-1:0] wen1, ren1, wen2, ren2, wen3, ren3;
  logic [DW-1:0]   wd1, wd2, wd3;
  logic [3:0]      be1, be2, be3;
  logic            err1, err2, err3;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  avalon_reg_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(DW)) if1 ();
  avalon_reg_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(DW)) if2 ();
  avalon_reg_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(DW)) if3 ();

  avalon_reg_bridge #(.REGS(REGS), .DATA_WIDTH(DW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .reg_write_en(wen1), .reg_read_en(ren1),
    .reg_wdata(wd1), .reg_byteen(be1), .reg_rdata(rdata), .reg_busy(b1), .err_sticky(err1));
  avalon_reg_bridge #(.REGS(REGS), .DATA_WIDTH(DW), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(if2), .reg_write_en(wen2), .reg_read_en(ren2),
    .reg_wdata(wd2), .reg_byteen(be2), .reg_rdata(rdata), .reg_busy(b2), .err_sticky(err2));
  avalon_reg_bridge #(.REGS(REGS), .DATA_WIDTH(DW), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3), .reg_write_en(wen3), .reg_read_en(ren3),
    .reg_wdata(wd3), .reg_byteen(be3), .reg_rdata(rdata), .reg_busy(b3), .err_sticky(err3));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        busy;
    logic [8:0]  xwen;
    logic [8:0]  xren;
    logic [31:0] xwd;
    logic [3:0]  xbe;
    logic        xrdv;
    logic [31:0] xrdata;
    logic [1:0]  xrsp;
    logic        xerr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int unsigned d, input logic rd, input logic wr,
                     input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
    case (d)
      1: begin
        if1.avs_read = rd; if1.avs_write = wr; if1.avs_address = a;
        if1.avs_writedata = wd; if1.avs_byteenable = be;
      end
      2: begin
        if2.avs_read = rd; if2.avs_write = wr; if2.avs_address = a;
        if2.avs_writedata = wd; if2.avs_byteenable = be;
      end
      default: begin
        if3.avs_read = rd; if3.avs_write = wr; if3.avs_address = a;
        if3.avs_writedata = wd; if3.avs_byteenable = be;
      end
    endcase
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rdv"},  {61'd0, if1.avs_readdatavalid, if2.avs_readdatavalid, if3.avs_readdatavalid}, 64'd0);
    chk({tag, ".rdata"}, {if1.avs_readdata | if2.avs_readdata, if3.avs_readdata}, 64'd0);
    chk({tag, ".rsp"},  {58'd0, if1.avs_response, if2.avs_response, if3.avs_response}, 64'd0);
    chk({tag, ".strb"}, {10'd0, wen1, ren1, wen2, ren2, wen3, ren3}, 64'd0);
    chk({tag, ".wdata"}, {wd1 | wd2, wd3}, 64'd0);
    chk({tag, ".be"},   {52'd0, be1, be2, be3}, 64'd0);
    chk({tag, ".err"},  {61'd0, err1, err2, err3}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(REGS); i++) rdata[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);

    //            rd    wr    addr   wdata          be    busy  wen     ren     wdata          be    rdv   rdata          rsp    err
    tbl[0] = '{1'b1, 1'b0, 4'd3,  32'h0,         4'h0, 1'b0, 9'h000, 9'h008, 32'h0,         4'h0, 1'b1, 32'hA5A5_0003, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'd5,  32'hDEAD_BEEF, 4'hF, 1'b0, 9'h020, 9'h000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         2'b00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'd1,  32'h0F0F_0F0F, 4'h6, 1'b0, 9'h002, 9'h000, 32'h0F0F_0F0F, 4'h6, 1'b0, 32'h0,         2'b00, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'd8,  32'h0,         4'h0, 1'b0, 9'h000, 9'h100, 32'h0,         4'h0, 1'b1, 32'hA5A5_0008, 2'b00, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'd0,  32'h0,         4'h0, 1'b0, 9'h000, 9'h001, 32'h0,         4'h0, 1'b1, 32'hA5A5_0000, 2'b00, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd1,  32'h0,         4'h0, 1'b1, 9'h000, 9'h000, 32'h0,         4'h0, 1'b0, 32'h0,         2'b00, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4'd9,  32'h0000_1111, 4'h1, 1'b0, 9'h000, 9'h000, 32'h0,         4'h0, 1'b0, 32'h0,         2'b00, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 4'd12, 32'h0,         4'h0, 1'b0, 9'h000, 9'h000, 32'h0,         4'h0, 1'b1, 32'h0,         2'b10, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 4'd4,  32'hCAFE_0004, 4'hC, 1'b0, 9'h010, 9'h000, 32'hCAFE_0004, 4'hC, 1'b0, 32'h0,         2'b00, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 4'd15, 32'h0,         4'h0, 1'b0, 9'h000, 9'h000, 32'h0,         4'h0, 1'b1, 32'h0,         2'b10, 1'b1};

    reset = 1'b1;
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
    for (int unsigned d = 1; d <= 3; d++) drv(d, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);

    // LATENCY=1 single-command vectors: strobe same cycle, response next cycle.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drv(1, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be);
      b1 = tbl[i].busy;
      @(negedge clk);
      chk($sformatf("v%0d.waitreq", i), {63'd0, if1.avs_waitrequest}, {63'd0, tbl[i].busy});
      chk($sformatf("v%0d.wen", i), {55'd0, wen1}, {55'd0, tbl[i].xwen});
      chk($sformatf("v%0d.ren", i), {55'd0, ren1}, {55'd0, tbl[i].xren});
      chk($sformatf("v%0d.wdata", i), {32'd0, wd1}, {32'd0, tbl[i].xwd});
      chk($sformatf("v%0d.be", i), {60'd0, be1}, {60'd0, tbl[i].xbe});
      @(posedge clk); #1;
      drv(1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      b1 = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d.rdv", i), {63'd0, if1.avs_readdatavalid}, {63'd0, tbl[i].xrdv});
      chk($sformatf("v%0d.rdata", i), {32'd0, if1.avs_readdata}, {32'd0, tbl[i].xrdata});
      chk($sformatf("v%0d.rsp", i), {62'd0, if1.avs_response}, {62'd0, tbl[i].xrsp});
      chk($sformatf("v%0d.err", i), {63'd0, err1}, {63'd0, tbl[i].xerr});
    end

    // LATENCY=3 write: strobe in N+2, never a response beat.
    @(posedge clk); #1;
    drv(3, 1'b0, 1'b1, 4'd2, 32'h1234_5678, 4'h3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("l3wr.c%0d.wen", c), {55'd0, wen3}, (c == 2) ? 64'h004 : 64'h0);
      chk($sformatf("l3wr.c%0d.wdata", c), {32'd0, wd3}, (c == 2) ? 64'h1234_5678 : 64'h0);
      chk($sformatf("l3wr.c%0d.be", c), {60'd0, be3}, (c == 2) ? 64'h3 : 64'h0);
      chk($sformatf("l3wr.c%0d.rdv", c), {63'd0, if3.avs_readdatavalid}, 64'd0);
      @(posedge clk); #1;
      drv(3, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    end

    // LATENCY=2 back-to-back reads of 0,1,2: beats in N+2..N+4, in order.
    @(posedge clk); #1;
    drv(2, 1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      logic [8:0] xren;
      @(negedge clk);
      xren = '0;
      if (c >= 1 && c <= 3) xren[c-1] = 1'b1;
      chk($sformatf("l2b2b.c%0d.ren", c), {55'd0, ren2}, {55'd0, xren});
      chk($sformatf("l2b2b.c%0d.rdv", c), {63'd0, if2.avs_readdatavalid},
          (c >= 2 && c <= 4) ? 64'd1 : 64'd0);
      chk($sformatf("l2b2b.c%0d.rdata", c), {32'd0, if2.avs_readdata},
          (c >= 2 && c <= 4) ? 64'hA5A5_0000 + 64'(c - 2) : 64'h0);
      @(posedge clk); #1;
      if (c + 1 < 3) drv(2, 1'b1, 1'b0, 4'(c + 1), 32'h0, 4'h0);
      else           drv(2, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    end

    // LATENCY=2 read with reg_busy in N+1..N+3: beat moves to N+5. A read
    // offered during the stall must be ignored; a stall while the beat is
    // on the bus (N+5) must not repeat it.
    @(posedge clk); #1;
    drv(2, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    b2 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("l2stall.c%0d.waitreq", c), {63'd0, if2.avs_waitrequest},
          ((c >= 1 && c <= 3) || c == 5) ? 64'd1 : 64'd0);
      chk($sformatf("l2stall.c%0d.ren", c), {55'd0, ren2}, (c == 4) ? 64'h020 : 64'h0);
      chk($sformatf("l2stall.c%0d.rdv", c), {63'd0, if2.avs_readdatavalid}, (c == 5) ? 64'd1 : 64'd0);
      chk($sformatf("l2stall.c%0d.rdata", c), {32'd0, if2.avs_readdata}, (c == 5) ? 64'hA5A5_0005 : 64'h0);
      @(posedge clk); #1;
      b2 = ((c + 1 >= 1 && c + 1 <= 3) || c + 1 == 5);
      if (c + 1 >= 1 && c + 1 <= 3) drv(2, 1'b1, 1'b0, 4'd6, 32'h0, 4'h0);
      else                          drv(2, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    end
    b2 = 1'b0;

    // LATENCY=2 read+write together: write performed, no beat, error flagged.
    @(posedge clk); #1;
    drv(2, 1'b1, 1'b1, 4'd6, 32'hCAFE_0006, 4'hF);
    @(negedge clk);
    chk("l2rw.err_before", {63'd0, err2}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("l2rw.c%0d.wen", c), {55'd0, wen2}, (c == 1) ? 64'h040 : 64'h0);
      chk($sformatf("l2rw.c%0d.wdata", c), {32'd0, wd2}, (c == 1) ? 64'hCAFE_0006 : 64'h0);
      chk($sformatf("l2rw.c%0d.ren", c), {55'd0, ren2}, 64'h0);
      chk($sformatf("l2rw.c%0d.rdv", c), {63'd0, if2.avs_readdatavalid}, 64'd0);
      @(posedge clk); #1;
      drv(2, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      @(negedge clk);
    end
    chk("l2rw.err_after", {63'd0, err2}, 64'd1);

    // LATENCY=3 out-of-range read: SLVERR beat with zero data in N+3.
    @(posedge clk); #1;
    drv(3, 1'b1, 1'b0, 4'd12, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("l3bad.c%0d.strb", c), {46'd0, wen3, ren3}, 64'h0);
      chk($sformatf("l3bad.c%0d.rdv", c), {63'd0, if3.avs_readdatavalid}, (c == 3) ? 64'd1 : 64'd0);
      chk($sformatf("l3bad.c%0d.rsp", c), {62'd0, if3.avs_response}, (c == 3) ? 64'd2 : 64'd0);
      chk($sformatf("l3bad.c%0d.rdata", c), {32'd0, if3.avs_readdata}, 64'h0);
      @(posedge clk); #1;
      drv(3, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    end
    chk("l3bad.err", {63'd0, err3}, 64'd1);

    // Two reads in flight on LATENCY=3, then reset: nothing comes back.
    drv(3, 1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    @(posedge clk); #1;
    drv(3, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    @(posedge clk); #1;
    drv(3, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("l3rst.c%0d.rdv", c), {63'd0, if3.avs_readdatavalid}, 64'd0);
      chk($sformatf("l3rst.c%0d.ren", c), {55'd0, ren3}, 64'h0);
      chk($sformatf("l3rst.c%0d.err", c), {63'd0, err3}, 64'd0);
      @(posedge clk); #1;
      if (c == 1) reset = 1'b0;
    end
    @(negedge clk);
    chk_idle("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
